// File: rtl/inst_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_loader_pkg : shared constants and FSM encoding for inst_loader   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package inst_loader_pkg;

    localparam int          ADDR_LINE  = 8;
    localparam int          D_SIZE     = 32;
    localparam int          MAX_CYCLES = 4096;
    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    // States from which a load_start pulse begins a fresh load.
    function automatic logic can_restart(input state_e s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_loader_run_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_timer : clearable, enabled cycle counter with terminal-count flag |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module run_timer
    import inst_loader_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int TERMINAL = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    assign at_limit = (count_q == WIDTH'(TERMINAL));

    // Holds at the terminal value so the flag stays asserted until cleared.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !at_limit) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_loader : streams a program into instruction memory, then runs    |
// | the pipeline until a halt word or the cycle limit.  Revision: 1.0     |
// +----------------------------------------------------------------------+
module inst_loader #(
    parameter int                ADDR_W     = inst_loader_pkg::ADDR_LINE,
    parameter int                D_SIZE     = inst_loader_pkg::D_SIZE,
    parameter logic [D_SIZE-1:0] HALT_WORD  = inst_loader_pkg::HALT_WORD,
    parameter int                MAX_CYCLES = inst_loader_pkg::MAX_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [D_SIZE-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [D_SIZE-1:0] imem_wdata,
    input  logic [D_SIZE-1:0] inst_fetched,
    output logic              core_valid,
    output logic              opr_finished,
    output logic              timeout,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    import inst_loader_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   WC_MAX    = {1'b1, {ADDR_W{1'b0}}};
    localparam int                TMR_W     = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

    state_e              state_d,    state_q;
    logic [ADDR_W-1:0]   ptr_d,      ptr_q;
    logic [ADDR_W:0]     wc_d,       wc_q;
    logic                we_d,       we_q;
    logic [ADDR_W-1:0]   addr_d,     addr_q;
    logic [D_SIZE-1:0]   wdata_d,    wdata_q;
    logic                timeout_d,  timeout_q;
    logic                overflow_d, overflow_q;

    logic w_restart;
    logic w_accept;
    logic w_halt;
    logic w_at_limit;

    assign w_restart = load_start && can_restart(state_q);
    assign w_accept  = (state_q == S_LOAD) && in_valid;
    assign w_halt    = (inst_fetched == HALT_WORD);

    run_timer #(
        .WIDTH    (TMR_W),
        .TERMINAL (MAX_CYCLES - 1)
    ) u_run_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_restart),
        .en       (state_q == S_RUN),
        .at_limit (w_at_limit)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wc_d       = wc_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_start) begin
                    state_d    = S_LOAD;
                    ptr_d      = '0;
                    wc_d       = '0;
                    timeout_d  = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    if (wc_q != WC_MAX) begin
                        wc_d = wc_q + (ADDR_W+1)'(1);
                    end
                    if (ptr_q != LAST_ADDR) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                    // A final word at the last address is a legal full program.
                    if (in_last) begin
                        state_d = S_FLUSH;
                    end else if (ptr_q == LAST_ADDR) begin
                        state_d    = S_ERR;
                        overflow_d = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (w_halt) begin
                    state_d = S_DONE;
                end else if (w_at_limit) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            wc_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wc_q       <= wc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready     = (state_q == S_LOAD);
    assign core_valid   = (state_q == S_RUN);
    assign opr_finished = (state_q == S_DONE);
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign timeout      = timeout_q;
    assign overflow     = overflow_q;
    assign word_count   = wc_q;

endmodule
`default_nettype wire
